// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Groups the fetch-stage control inputs, the instruction-memory port and the
//   IF/ID outputs into one bundle.
//   master : pipeline/environment side. It drives the stall, branch, flush and
//            imem data signals, and it observes the fetch outputs.
//   slave  : the fetch stage itself.
//   Handshake: there is no valid/ready pair. imem_addr_out is presented
//   combinationally from the PC register. imem_data_in must answer it before
//   the next posedge. stall_in is a level hold sampled at each posedge. While
//   it is high, nothing in the fetch stage advances.
interface fetch_stage_if;
  logic        stall_in;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic        flush_in;
  logic [31:0] flush_target_in;
  logic [31:0] imem_addr_out;
  logic [31:0] imem_data_in;
  logic [31:0] pc_out;
  logic [31:0] id_pc_out;
  logic [31:0] id_instr_out;
  logic        id_valid_out;
  logic [15:0] stall_count_out;

  modport master (
    output stall_in, branch_taken_in, branch_target_in,
    output flush_in, flush_target_in, imem_data_in,
    input  imem_addr_out, pc_out, id_pc_out, id_instr_out,
    input  id_valid_out, stall_count_out
  );

  modport slave (
    input  stall_in, branch_taken_in, branch_target_in,
    input  flush_in, flush_target_in, imem_data_in,
    output imem_addr_out, pc_out, id_pc_out, id_instr_out,
    output id_valid_out, stall_count_out
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register of a 5-stage MIPS
//   pipeline. It holds the PC and drives the instruction-memory address. Each
//   cycle it latches the fetched word and its PC into IF/ID for decode.
//   Ports:
//     clock : pipeline clock. All state changes on posedge.
//     reset : asynchronous, active-low.
//     bus   : fetch_stage_if.slave. It carries stall, branch and flush
//             controls, the imem address/data pair, the PC, the IF/ID fields
//             and a saturating stall counter.
//   Parameters:
//     RESET_PC   : PC loaded on reset.
//     DELAY_SLOT : 1 executes the instruction after a taken branch.
//                  0 squashes that instruction into a bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  fetch_stage_if.slave bus
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_q,       pc_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] branch_tgt;
  logic [31:0] flush_tgt;

  // Redirect targets are always word aligned. Any low bits set by the
  // producer are ignored.
  assign branch_tgt = bus.branch_target_in & ALIGN_MASK;
  assign flush_tgt  = bus.flush_target_in  & ALIGN_MASK;

  // Next-state logic. One priority chain serves both the PC and IF/ID:
  // flush > stall > branch > sequential.
  always_comb begin
    pc_d        = pc_q + 32'd4;   // modulo 2^32, so 0xFFFF_FFFC wraps to 0
    id_pc_d     = pc_q;
    id_instr_d  = bus.imem_data_in;
    id_valid_d  = 1'b1;
    stall_cnt_d = stall_cnt_q;

    if (bus.flush_in) begin
      pc_d       = flush_tgt;
      id_pc_d    = 32'h0;
      id_instr_d = 32'h0;
      id_valid_d = 1'b0;
    end else if (bus.stall_in) begin
      // The branch in ID is not resolved while stalled, so it is ignored
      // here. It must be re-presented on the first unstalled cycle.
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
      if (stall_cnt_q != 16'hFFFF) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end else if (bus.branch_taken_in) begin
      pc_d = branch_tgt;
      if (DELAY_SLOT == 1'b0) begin
        id_pc_d    = 32'h0;
        id_instr_d = 32'h0;
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      id_pc_q     <= 32'h0;
      id_instr_q  <= 32'h0;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= 16'h0;
    end else begin
      pc_q        <= pc_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.imem_addr_out   = pc_q;
  assign bus.pc_out          = pc_q;
  assign bus.id_pc_out       = id_pc_q;
  assign bus.id_instr_out    = id_instr_q;
  assign bus.id_valid_out    = id_valid_q;
  assign bus.stall_count_out = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage. Two instances run in lockstep on the same
//   controls: one with DELAY_SLOT = 1 and one with DELAY_SLOT = 0. Each one's
//   instruction memory returns addr ^ 32'hA5A5_0000.
module tb_fetch_stage;

  logic clock;
  logic reset;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_stage_if if_ds1();
  fetch_stage_if if_ds0();

  assign if_ds1.imem_data_in = if_ds1.imem_addr_out ^ 32'hA5A5_0000;
  assign if_ds0.imem_data_in = if_ds0.imem_addr_out ^ 32'hA5A5_0000;

  fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b1)) u_ds1 (
    .clock (clock),
    .reset (reset),
    .bus   (if_ds1.slave)
  );

  fetch_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1'b0)) u_ds0 (
    .clock (clock),
    .reset (reset),
    .bus   (if_ds0.slave)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // driver tasks
  task automatic set_in(input logic stall, input logic br, input logic [31:0] bt,
                        input logic fl, input logic [31:0] ft);
    if_ds1.stall_in = stall;  if_ds0.stall_in = stall;
    if_ds1.branch_taken_in = br;  if_ds0.branch_taken_in = br;
    if_ds1.branch_target_in = bt; if_ds0.branch_target_in = bt;
    if_ds1.flush_in = fl;  if_ds0.flush_in = fl;
    if_ds1.flush_target_in = ft; if_ds0.flush_target_in = ft;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // advance one posedge and sample 1 ns later
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #3;
    // async reset values, before any clock edge
    check("rst_pc",     if_ds1.pc_out, 32'h0);
    check("rst_idpc",   if_ds1.id_pc_out, 32'h0);
    check("rst_instr",  if_ds1.id_instr_out, 32'h0);
    check("rst_valid",  {31'h0, if_ds1.id_valid_out}, 32'h0);
    check("rst_cnt",    {16'h0, if_ds1.stall_count_out}, 32'h0);
    check("rst_pc_ds0", if_ds0.pc_out, 32'h0);

    #9 reset = 1'b1;   // released between edges (t=12)
    check("rel_valid", {31'h0, if_ds1.id_valid_out}, 32'h0);

    // sequential fetch
    tick();
    check("seq_pc4",    if_ds1.pc_out, 32'h4);
    check("seq_instr0", if_ds1.id_instr_out, 32'hA5A5_0000);
    check("seq_idpc0",  if_ds1.id_pc_out, 32'h0);
    check("seq_valid",  {31'h0, if_ds1.id_valid_out}, 32'h1);
    tick();
    check("seq_pc8",    if_ds1.pc_out, 32'h8);
    check("seq_instr4", if_ds1.id_instr_out, 32'hA5A5_0004);
    tick();
    tick();
    check("seq_pc10",   if_ds1.pc_out, 32'h10);

    // two stalled edges at pc = 0x10
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    check("stl1_pc",    if_ds1.pc_out, 32'h10);
    check("stl1_instr", if_ds1.id_instr_out, 32'hA5A5_000C);
    check("stl1_cnt",   {16'h0, if_ds1.stall_count_out}, 32'h1);
    tick();
    check("stl2_pc",    if_ds1.pc_out, 32'h10);
    check("stl2_idpc",  if_ds1.id_pc_out, 32'hC);
    check("stl2_cnt",   {16'h0, if_ds1.stall_count_out}, 32'h2);
    idle();
    tick();
    check("unstl_pc",    if_ds1.pc_out, 32'h14);
    check("unstl_instr", if_ds1.id_instr_out, 32'hA5A5_0010);
    check("unstl_cnt",   {16'h0, if_ds1.stall_count_out}, 32'h2);

    // taken branch at pc = 0x20 to 0x103
    tick(); tick(); tick();
    check("br_at_pc", if_ds1.pc_out, 32'h20);
    set_in(1'b0, 1'b1, 32'h103, 1'b0, 32'h0);
    tick();
    check("br_ds1_pc",    if_ds1.pc_out, 32'h100);
    check("br_ds1_instr", if_ds1.id_instr_out, 32'hA5A5_0020);
    check("br_ds1_idpc",  if_ds1.id_pc_out, 32'h20);
    check("br_ds1_valid", {31'h0, if_ds1.id_valid_out}, 32'h1);
    check("br_ds0_pc",    if_ds0.pc_out, 32'h100);
    check("br_ds0_instr", if_ds0.id_instr_out, 32'h0);
    check("br_ds0_idpc",  if_ds0.id_pc_out, 32'h0);
    check("br_ds0_valid", {31'h0, if_ds0.id_valid_out}, 32'h0);
    idle();
    tick();
    check("abr_ds0_instr", if_ds0.id_instr_out, 32'hA5A5_0100);
    check("abr_ds0_valid", {31'h0, if_ds0.id_valid_out}, 32'h1);
    check("abr_pc",        if_ds1.pc_out, 32'h104);

    // flush + stall + branch together
    set_in(1'b1, 1'b1, 32'h200, 1'b1, 32'h182);
    tick();
    check("fl_pc",    if_ds1.pc_out, 32'h180);
    check("fl_valid", {31'h0, if_ds1.id_valid_out}, 32'h0);
    check("fl_instr", if_ds1.id_instr_out, 32'h0);
    check("fl_cnt",   {16'h0, if_ds1.stall_count_out}, 32'h2);
    idle();
    tick();
    check("afl_instr", if_ds1.id_instr_out, 32'hA5A5_0180);
    check("afl_idpc",  if_ds1.id_pc_out, 32'h180);
    check("afl_valid", {31'h0, if_ds1.id_valid_out}, 32'h1);

    // stall + branch: stall wins, branch taken on first free edge
    set_in(1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    check("sb_pc",  if_ds1.pc_out, 32'h184);
    check("sb_cnt", {16'h0, if_ds1.stall_count_out}, 32'h3);
    set_in(1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    tick();
    check("sb_go_pc",  if_ds1.pc_out, 32'h300);
    check("sb_ds0_vl", {31'h0, if_ds0.id_valid_out}, 32'h0);

    // saturation of the stall counter
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 65531; i++) tick();
    check("sat_near", {16'h0, if_ds1.stall_count_out}, 32'hFFFE);
    for (int i = 0; i < 4; i++) tick();
    check("sat_cnt", {16'h0, if_ds1.stall_count_out}, 32'hFFFF);
    check("sat_pc",  if_ds1.pc_out, 32'h300);

    // PC wrap
    set_in(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tick();
    check("wrap_top", if_ds1.pc_out, 32'hFFFF_FFFC);
    idle();
    tick();
    check("wrap_pc",    if_ds1.pc_out, 32'h0);
    check("wrap_instr", if_ds1.id_instr_out, 32'h5A5A_FFFC);
    check("wrap_idpc",  if_ds1.id_pc_out, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc4", if_ds1.pc_out, 32'h4);

    // async reset between edges
    #3 reset = 1'b0;
    #1;
    check("arst_pc",    if_ds1.pc_out, 32'h0);
    check("arst_valid", {31'h0, if_ds1.id_valid_out}, 32'h0);
    check("arst_cnt",   {16'h0, if_ds1.stall_count_out}, 32'h0);
    // release with stall high: pc stays at RESET_PC
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #2 reset = 1'b1;
    tick();
    check("rrel_pc",  if_ds1.pc_out, 32'h0);
    check("rrel_cnt", {16'h0, if_ds1.stall_count_out}, 32'h1);
    idle();
    tick();
    check("rrel_pc4",   if_ds1.pc_out, 32'h4);
    check("rrel_instr", if_ds1.id_instr_out, 32'hA5A5_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
